// File: rtl/start_pkg.sv
// start_pkg: shared types and defaults for the start-burst generator.
// Imported by the top and its counter sub-module.
package start_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      GAP    = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam int CNT_W_DEF = 4;
   localparam int REP_W_DEF = 4;

endpackage

// File: rtl/start_burst_gen_down_counter_ld.sv
// down_counter_ld: loadable down-counter with a zero flag.
// Holds at zero rather than wrapping.
module down_counter_ld #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic         dec,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] count;

   // load wins over decrement; decrement saturates at zero
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/start_burst_gen.sv
// start_burst_gen: programmable start-strobe burst generator.
// Shadows the receiver's high-cycle count in pulse_count.
module start_burst_gen
   import start_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF,
   parameter int REP_W = REP_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [CNT_W-1:0] cfg_len,
   input  logic [CNT_W-1:0] cfg_gap,
   input  logic [REP_W-1:0] cfg_reps,
   input  logic             abort,
   output logic             start,
   output logic             busy,
   output logic             done,
   output logic             aborted,
   output logic [CNT_W-1:0] pulse_count
);

   state_t           state;
   logic [CNT_W-1:0] len_q;
   logic [CNT_W-1:0] gap_q;

   logic             accept;
   logic             degen;

   logic             cyc_ld;
   logic             cyc_dec;
   logic [CNT_W-1:0] cyc_val;
   logic             cyc_zero;

   logic             rep_ld;
   logic             rep_dec;
   logic [REP_W-1:0] rep_val;
   logic             rep_zero;

   assign accept = cfg_valid && cfg_ready;
   assign degen  = (cfg_len == '0) || (cfg_reps == '0);

   // counters hold "cycles left minus one" for the current phase
   always_comb begin
      cyc_ld  = 1'b0;
      cyc_dec = 1'b0;
      cyc_val = len_q - 1'b1;
      rep_ld  = 1'b0;
      rep_dec = 1'b0;
      rep_val = cfg_reps - 1'b1;
      unique case (state)
         IDLE: begin
            if (accept && !degen) begin
               cyc_ld  = 1'b1;
               cyc_val = cfg_len - 1'b1;
               rep_ld  = 1'b1;
            end
         end
         ACTIVE: begin
            if (!abort) begin
               if (!cyc_zero) begin
                  cyc_dec = 1'b1;
               end else if (!rep_zero) begin
                  cyc_ld  = 1'b1;
                  rep_dec = 1'b1;
                  if (gap_q != '0) begin
                     cyc_val = gap_q - 1'b1;
                  end
               end
            end
         end
         GAP: begin
            if (!abort) begin
               if (cyc_zero) begin
                  cyc_ld = 1'b1;
               end else begin
                  cyc_dec = 1'b1;
               end
            end
         end
         DONE: begin
         end
      endcase
   end

   down_counter_ld #(.W(CNT_W)) u_cyc_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (cyc_ld),
      .dec      (cyc_dec),
      .load_val (cyc_val),
      .zero     (cyc_zero)
   );

   down_counter_ld #(.W(REP_W)) u_rep_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (rep_ld),
      .dec      (rep_dec),
      .load_val (rep_val),
      .zero     (rep_zero)
   );

   // control FSM; all handshake and strobe outputs are registered
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         len_q     <= '0;
         gap_q     <= '0;
         start     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         aborted   <= 1'b0;
         cfg_ready <= 1'b1;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (accept) begin
                  len_q     <= cfg_len;
                  gap_q     <= cfg_gap;
                  aborted   <= 1'b0;
                  cfg_ready <= 1'b0;
                  if (degen) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= ACTIVE;
                     start <= 1'b1;
                     busy  <= 1'b1;
                  end
               end
            end
            ACTIVE: begin
               if (abort) begin
                  state   <= DONE;
                  start   <= 1'b0;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  aborted <= 1'b1;
               end else if (cyc_zero) begin
                  if (rep_zero) begin
                     state <= DONE;
                     start <= 1'b0;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else if (gap_q != '0) begin
                     state <= GAP;
                     start <= 1'b0;
                  end
               end
            end
            GAP: begin
               if (abort) begin
                  state   <= DONE;
                  start   <= 1'b0;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  aborted <= 1'b1;
               end else if (cyc_zero) begin
                  state <= ACTIVE;
                  start <= 1'b1;
               end
            end
            DONE: begin
               state     <= IDLE;
               cfg_ready <= 1'b1;
            end
         endcase
      end
   end

   // shadow of the receiver's counter: one count per high start cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pulse_count <= '0;
      end else if (start) begin
         pulse_count <= pulse_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_start_burst_gen.sv
// tb_start_burst_gen: directed checks for start_burst_gen.
// Includes a model of the downstream start-counting receiver.
module tb_start_burst_gen;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       cfg_valid = 1'b0;
   logic       cfg_ready;
   logic [3:0] cfg_len = '0;
   logic [3:0] cfg_gap = '0;
   logic [3:0] cfg_reps = '0;
   logic       abort = 1'b0;
   logic       start;
   logic       busy;
   logic       done;
   logic       aborted;
   logic [3:0] pulse_count;

   logic       rx_q;
   logic [3:0] rx_cnt;

   int n_chk  = 0;
   int n_pass = 0;

   logic [63:0] tr;
   int          done_at;
   logic        ab_seen;
   int          busy_n;
   int          n_done;

   always #5 clk = ~clk;

   start_burst_gen dut (
      .clk         (clk),
      .reset       (reset),
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready),
      .cfg_len     (cfg_len),
      .cfg_gap     (cfg_gap),
      .cfg_reps    (cfg_reps),
      .abort       (abort),
      .start       (start),
      .busy        (busy),
      .done        (done),
      .aborted     (aborted),
      .pulse_count (pulse_count)
   );

   // receiver: input register, then counter register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_q   <= 1'b0;
         rx_cnt <= '0;
      end else begin
         rx_q <= start;
         if (rx_q) rx_cnt <= rx_cnt + 1'b1;
      end
   end

   task automatic check(input string tag,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic run_job(input int len, input int gap,
                          input int reps, input int abort_cyc,
                          input bit ab_acc);
      tr      = '0;
      done_at = -1;
      ab_seen = 1'b0;
      busy_n  = 0;
      @(negedge clk);
      check("ready_before", cfg_ready, 1);
      cfg_valid = 1'b1;
      cfg_len   = len[3:0];
      cfg_gap   = gap[3:0];
      cfg_reps  = reps[3:0];
      abort     = ab_acc;
      @(posedge clk);
      #1;
      cfg_valid = 1'b0;
      abort     = 1'b0;
      cfg_len   = 4'hF;
      cfg_gap   = 4'hF;
      cfg_reps  = 4'hF;
      for (int k = 1; k < 64 && done_at < 0; k++) begin
         @(negedge clk);
         tr[k] = start;
         if (busy) busy_n++;
         if (done) begin
            done_at = k;
            ab_seen = aborted;
         end
         if (k == abort_cyc) abort = 1'b1;
         @(posedge clk);
         #1;
         abort = 1'b0;
      end
      if (done_at < 0) check("done_timeout", 0, 1);
   endtask

   initial begin
      @(negedge clk);
      check("rst_start", start, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_abrt", aborted, 0);
      check("rst_pcnt", pulse_count, 0);
      check("rst_ready", cfg_ready, 1);
      do_reset();

      run_job(3, 2, 2, 0, 1'b0);
      check("basic_tr", tr, 64'h1CE);
      check("basic_done", done_at, 9);
      check("basic_abrt", ab_seen, 0);
      check("basic_pcnt", pulse_count, 6);
      repeat (2) @(negedge clk);
      check("basic_rx", rx_cnt, 6);

      do_reset();
      run_job(4, 0, 3, 0, 1'b0);
      check("zgap_tr", tr, 64'h1FFE);
      check("zgap_done", done_at, 13);
      check("zgap_busy", busy_n, 12);
      check("zgap_pcnt", pulse_count, 12);

      run_job(0, 3, 5, 0, 1'b0);
      check("deg0_tr", tr, 0);
      check("deg0_done", done_at, 1);
      check("deg0_pcnt", pulse_count, 12);
      run_job(5, 3, 0, 0, 1'b0);
      check("deg1_tr", tr, 0);
      check("deg1_done", done_at, 1);
      check("deg1_busy", busy_n, 0);
      check("deg1_pcnt", pulse_count, 12);

      do_reset();
      run_job(15, 1, 2, 0, 1'b0);
      check("wrap_tr", tr, 64'hFFFE_FFFE);
      check("wrap_done", done_at, 32);
      check("wrap_pcnt", pulse_count, 14);
      repeat (2) @(negedge clk);
      check("wrap_rx", rx_cnt, 14);

      do_reset();
      run_job(10, 0, 1, 4, 1'b0);
      check("abrt_tr", tr, 64'h1E);
      check("abrt_done", done_at, 5);
      check("abrt_flag", ab_seen, 1);
      check("abrt_pcnt", pulse_count, 4);
      check("abrt_hold", aborted, 1);
      run_job(10, 0, 1, 0, 1'b1);
      check("idab_tr", tr, 64'h7FE);
      check("idab_done", done_at, 11);
      check("idab_flag", ab_seen, 0);
      check("idab_pcnt", pulse_count, 14);

      run_job(3, 5, 2, 0, 1'b0);
      // run_job returned at done; start a job to cut into
      @(negedge clk);
      cfg_valid = 1'b1;
      cfg_len   = 4'd3;
      cfg_gap   = 4'd5;
      cfg_reps  = 4'd2;
      @(posedge clk);
      #1;
      cfg_valid = 1'b0;
      repeat (5) @(negedge clk);
      check("mid_in_gap", {busy, start}, 2'b10);
      #2;
      reset = 1'b1;
      #1;
      check("mid_start", start, 0);
      check("mid_busy", busy, 0);
      check("mid_done", done, 0);
      check("mid_pcnt", pulse_count, 0);
      check("mid_ready", cfg_ready, 1);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      n_done = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (done) n_done++;
      end
      check("post_done", n_done, 0);
      check("post_ready", cfg_ready, 1);
      check("post_pcnt", pulse_count, 0);
      check("post_start", start, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
